// File: rtl/reservation_station.sv
// Out-of-order reservation station: holds dispatched ops and snoops both CDBs for operand wakeup.
// Issues the lowest-index ready entry to the ALU, at most one per cycle.
module reservation_station #(
    parameter int unsigned RS_SIZE   = 16,
    parameter int unsigned RS_IDX_W  = 4,
    parameter int unsigned ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 clear,
    input  logic                 RS_flag,
    input  logic [RS_IDX_W-1:0]  RS_put_idx,
    input  logic [5:0]           Dis_op,
    input  logic [31:0]          Dis_imm,
    input  logic [4:0]           Dis_rd,
    input  logic [ROB_IDX_W-1:0] Dis_ROB_idx,
    input  logic [31:0]          Dis_PC,
    input  logic [31:0]          Dis_BTB_PC,
    input  logic                 Dis_BTB_predict,
    input  logic                 Dis_R1,
    input  logic                 Dis_R2,
    input  logic [31:0]          Dis_V1,
    input  logic [31:0]          Dis_V2,
    input  logic                 ALU_cdb_flag,
    input  logic [ROB_IDX_W-1:0] ALU_cdb_idx,
    input  logic [31:0]          ALU_cdb_val,
    input  logic                 LSB_cdb_flag,
    input  logic [ROB_IDX_W-1:0] LSB_cdb_idx,
    input  logic [31:0]          LSB_cdb_val,
    output logic [RS_IDX_W-1:0]  RS_put_idx_out,
    output logic                 RS_full,
    output logic                 RS_ready_out,
    output logic [RS_IDX_W-1:0]  RS_ready_idx_out,
    output logic                 ALU_issue,
    output logic [5:0]           ALU_op,
    output logic [31:0]          ALU_V1,
    output logic [31:0]          ALU_V2,
    output logic [31:0]          ALU_imm,
    output logic [31:0]          ALU_PC,
    output logic [31:0]          ALU_BTB_PC,
    output logic [4:0]           ALU_rd,
    output logic [ROB_IDX_W-1:0] ALU_ROB_idx,
    output logic                 ALU_BTB_predict
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned RD_W   = 5;

    typedef struct packed {
        logic                 busy;
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    imm;
        logic [RD_W-1:0]      rd;
        logic [ROB_IDX_W-1:0] rob;
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    btb_pc;
        logic                 pred;
        logic                 r1;
        logic [DATA_W-1:0]    v1;
        logic                 r2;
        logic [DATA_W-1:0]    v2;
    } entry_t;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    imm;
        logic [RD_W-1:0]      rd;
        logic [ROB_IDX_W-1:0] rob;
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    btb_pc;
        logic                 pred;
        logic [DATA_W-1:0]    v1;
        logic [DATA_W-1:0]    v2;
    } alu_t;

    entry_t entry_q [RS_SIZE];
    entry_t entry_d [RS_SIZE];
    alu_t   alu_q, alu_d;
    logic   issue_q, issue_d;

    logic [RS_IDX_W-1:0] free_idx_c, ready_idx_c;
    logic                full_c, ready_c;

    // Returns {ready, value}; a pending operand picks up a matching CDB, ALU bus first.
    function automatic logic [DATA_W:0] snoop(
        input logic                 r,
        input logic [DATA_W-1:0]    v,
        input logic                 af,
        input logic [ROB_IDX_W-1:0] ai,
        input logic [DATA_W-1:0]    av,
        input logic                 lf,
        input logic [ROB_IDX_W-1:0] li,
        input logic [DATA_W-1:0]    lv
    );
        if (r)                                return {1'b1, v};
        if (af && (ai == v[ROB_IDX_W-1:0]))  return {1'b1, av};
        if (lf && (li == v[ROB_IDX_W-1:0]))  return {1'b1, lv};
        return {1'b0, v};
    endfunction

    // Lowest-index free and issuable entries; scanning downward lets the lowest win.
    always_comb begin
        free_idx_c  = '0;
        ready_idx_c = '0;
        full_c      = 1'b1;
        ready_c     = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!entry_q[i].busy) begin
                free_idx_c = RS_IDX_W'(i);
                full_c     = 1'b0;
            end
            if (entry_q[i].busy && entry_q[i].r1 && entry_q[i].r2) begin
                ready_idx_c = RS_IDX_W'(i);
                ready_c     = 1'b1;
            end
        end
    end

    // Next state: clear beats everything; otherwise wakeup, issue and put in the same edge.
    always_comb begin
        entry_d = entry_q;
        alu_d   = alu_q;
        issue_d = 1'b0;
        if (rdy) begin
            if (clear) begin
                for (int i = 0; i < RS_SIZE; i++) entry_d[i].busy = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (entry_q[i].busy) begin
                        {entry_d[i].r1, entry_d[i].v1} = snoop(entry_q[i].r1, entry_q[i].v1,
                            ALU_cdb_flag, ALU_cdb_idx, ALU_cdb_val, LSB_cdb_flag, LSB_cdb_idx, LSB_cdb_val);
                        {entry_d[i].r2, entry_d[i].v2} = snoop(entry_q[i].r2, entry_q[i].v2,
                            ALU_cdb_flag, ALU_cdb_idx, ALU_cdb_val, LSB_cdb_flag, LSB_cdb_idx, LSB_cdb_val);
                    end
                end
                if (ready_c) begin
                    alu_d = '{op: entry_q[ready_idx_c].op, imm: entry_q[ready_idx_c].imm,
                              rd: entry_q[ready_idx_c].rd, rob: entry_q[ready_idx_c].rob,
                              pc: entry_q[ready_idx_c].pc, btb_pc: entry_q[ready_idx_c].btb_pc,
                              pred: entry_q[ready_idx_c].pred, v1: entry_q[ready_idx_c].v1,
                              v2: entry_q[ready_idx_c].v2};
                    issue_d = 1'b1;
                    entry_d[ready_idx_c].busy = 1'b0;
                end
                if (RS_flag && !full_c) begin
                    entry_d[RS_put_idx].busy   = 1'b1;
                    entry_d[RS_put_idx].op     = Dis_op;
                    entry_d[RS_put_idx].imm    = Dis_imm;
                    entry_d[RS_put_idx].rd     = Dis_rd;
                    entry_d[RS_put_idx].rob    = Dis_ROB_idx;
                    entry_d[RS_put_idx].pc     = Dis_PC;
                    entry_d[RS_put_idx].btb_pc = Dis_BTB_PC;
                    entry_d[RS_put_idx].pred   = Dis_BTB_predict;
                    {entry_d[RS_put_idx].r1, entry_d[RS_put_idx].v1} = snoop(Dis_R1, Dis_V1,
                        ALU_cdb_flag, ALU_cdb_idx, ALU_cdb_val, LSB_cdb_flag, LSB_cdb_idx, LSB_cdb_val);
                    {entry_d[RS_put_idx].r2, entry_d[RS_put_idx].v2} = snoop(Dis_R2, Dis_V2,
                        ALU_cdb_flag, ALU_cdb_idx, ALU_cdb_val, LSB_cdb_flag, LSB_cdb_idx, LSB_cdb_val);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) entry_q[i] <= '0;
            alu_q   <= '0;
            issue_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            alu_q   <= alu_d;
            issue_q <= issue_d;
        end
    end

    assign RS_put_idx_out   = free_idx_c;
    assign RS_full          = full_c;
    assign RS_ready_out     = ready_c;
    assign RS_ready_idx_out = ready_idx_c;
    assign ALU_issue        = issue_q;
    assign ALU_op           = alu_q.op;
    assign ALU_V1           = alu_q.v1;
    assign ALU_V2           = alu_q.v2;
    assign ALU_imm          = alu_q.imm;
    assign ALU_PC           = alu_q.pc;
    assign ALU_BTB_PC       = alu_q.btb_pc;
    assign ALU_rd           = alu_q.rd;
    assign ALU_ROB_idx      = alu_q.rob;
    assign ALU_BTB_predict  = alu_q.pred;
endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station: dispatch, wakeup, forwarding, full, clear and reset.
module tb_reservation_station;
    logic        clk, rst_n, rdy, clear, RS_flag;
    logic [3:0]  RS_put_idx;
    logic [5:0]  Dis_op;
    logic [31:0] Dis_imm, Dis_PC, Dis_BTB_PC, Dis_V1, Dis_V2;
    logic [4:0]  Dis_rd;
    logic [3:0]  Dis_ROB_idx;
    logic        Dis_BTB_predict, Dis_R1, Dis_R2;
    logic        ALU_cdb_flag, LSB_cdb_flag;
    logic [3:0]  ALU_cdb_idx, LSB_cdb_idx;
    logic [31:0] ALU_cdb_val, LSB_cdb_val;
    logic [3:0]  RS_put_idx_out, RS_ready_idx_out;
    logic        RS_full, RS_ready_out, ALU_issue, ALU_BTB_predict;
    logic [5:0]  ALU_op;
    logic [31:0] ALU_V1, ALU_V2, ALU_imm, ALU_PC, ALU_BTB_PC;
    logic [4:0]  ALU_rd;
    logic [3:0]  ALU_ROB_idx;

    int checks = 0;
    int failures = 0;

    reservation_station dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear), .RS_flag(RS_flag),
        .RS_put_idx(RS_put_idx), .Dis_op(Dis_op), .Dis_imm(Dis_imm), .Dis_rd(Dis_rd),
        .Dis_ROB_idx(Dis_ROB_idx), .Dis_PC(Dis_PC), .Dis_BTB_PC(Dis_BTB_PC),
        .Dis_BTB_predict(Dis_BTB_predict), .Dis_R1(Dis_R1), .Dis_R2(Dis_R2),
        .Dis_V1(Dis_V1), .Dis_V2(Dis_V2),
        .ALU_cdb_flag(ALU_cdb_flag), .ALU_cdb_idx(ALU_cdb_idx), .ALU_cdb_val(ALU_cdb_val),
        .LSB_cdb_flag(LSB_cdb_flag), .LSB_cdb_idx(LSB_cdb_idx), .LSB_cdb_val(LSB_cdb_val),
        .RS_put_idx_out(RS_put_idx_out), .RS_full(RS_full), .RS_ready_out(RS_ready_out),
        .RS_ready_idx_out(RS_ready_idx_out), .ALU_issue(ALU_issue), .ALU_op(ALU_op),
        .ALU_V1(ALU_V1), .ALU_V2(ALU_V2), .ALU_imm(ALU_imm), .ALU_PC(ALU_PC),
        .ALU_BTB_PC(ALU_BTB_PC), .ALU_rd(ALU_rd), .ALU_ROB_idx(ALU_ROB_idx),
        .ALU_BTB_predict(ALU_BTB_predict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RS_flag = 1'b0; clear = 1'b0; ALU_cdb_flag = 1'b0; LSB_cdb_flag = 1'b0;
    endtask

    task automatic put(input logic [3:0] idx, input logic r1, input logic [31:0] v1,
                       input logic r2, input logic [31:0] v2, input logic [3:0] rob);
        RS_flag = 1'b1; RS_put_idx = idx; Dis_op = 6'd1; Dis_imm = 32'(rob) + 32'h100;
        Dis_rd = 5'(rob); Dis_ROB_idx = rob; Dis_PC = 32'h1000 + 32'(rob);
        Dis_BTB_PC = 32'h2000; Dis_BTB_predict = rob[0];
        Dis_R1 = r1; Dis_V1 = v1; Dis_R2 = r2; Dis_V2 = v2;
    endtask

    task automatic test_reset();
        checks++; if (ALU_issue !== 1'b0) begin failures++; $display("FAIL reset_issue: got %0h want 0", ALU_issue); end
        checks++; if (RS_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %0h want 0", RS_full); end
        checks++; if (RS_put_idx_out !== 4'd0) begin failures++; $display("FAIL reset_put_idx: got %0h want 0", RS_put_idx_out); end
        checks++; if (RS_ready_out !== 1'b0 || RS_ready_idx_out !== 4'd0) begin failures++; $display("FAIL reset_ready: got %0h/%0h want 0/0", RS_ready_out, RS_ready_idx_out); end
        checks++; if (ALU_V1 !== 32'd0 || ALU_op !== 6'd0) begin failures++; $display("FAIL reset_alu_data: got %0h/%0h want 0/0", ALU_V1, ALU_op); end
    endtask

    task automatic test_issue_ready();
        put(4'd0, 1'b1, 32'd5, 1'b1, 32'd7, 4'd3);
        tick(); idle();
        checks++; if (ALU_issue !== 1'b0 || RS_ready_out !== 1'b1) begin failures++; $display("FAIL add_after_put: issue %0h ready %0h want 0/1", ALU_issue, RS_ready_out); end
        checks++; if (RS_put_idx_out !== 4'd1) begin failures++; $display("FAIL add_put_idx: got %0h want 1", RS_put_idx_out); end
        tick();
        checks++; if (ALU_issue !== 1'b1) begin failures++; $display("FAIL add_issue: got %0h want 1", ALU_issue); end
        checks++; if (ALU_V1 !== 32'd5 || ALU_V2 !== 32'd7) begin failures++; $display("FAIL add_vals: got %0h/%0h want 5/7", ALU_V1, ALU_V2); end
        checks++; if (ALU_ROB_idx !== 4'd3 || ALU_op !== 6'd1 || ALU_imm !== 32'h103 || ALU_PC !== 32'h1003 || ALU_rd !== 5'd3 || ALU_BTB_predict !== 1'b1)
            begin failures++; $display("FAIL add_fields: rob %0h op %0h imm %0h pc %0h want 3/1/103/1003", ALU_ROB_idx, ALU_op, ALU_imm, ALU_PC); end
        checks++; if (RS_full !== 1'b0 || RS_ready_out !== 1'b0) begin failures++; $display("FAIL add_after_issue: full %0h ready %0h want 0/0", RS_full, RS_ready_out); end
        tick();
        checks++; if (ALU_issue !== 1'b0 || ALU_V1 !== 32'd5) begin failures++; $display("FAIL add_hold: issue %0h v1 %0h want 0/5", ALU_issue, ALU_V1); end
    endtask

    task automatic test_wakeup();
        put(4'd0, 1'b0, 32'd2, 1'b1, 32'd3, 4'd5);
        tick(); idle();
        tick();
        checks++; if (ALU_issue !== 1'b0 || RS_ready_out !== 1'b0) begin failures++; $display("FAIL wake_wait: issue %0h ready %0h want 0/0", ALU_issue, RS_ready_out); end
        ALU_cdb_flag = 1'b1; ALU_cdb_idx = 4'd2; ALU_cdb_val = 32'h10;
        LSB_cdb_flag = 1'b1; LSB_cdb_idx = 4'd2; LSB_cdb_val = 32'h99;
        tick(); idle();
        checks++; if (ALU_issue !== 1'b0 || RS_ready_out !== 1'b1) begin failures++; $display("FAIL wake_ready: issue %0h ready %0h want 0/1", ALU_issue, RS_ready_out); end
        tick();
        checks++; if (ALU_issue !== 1'b1 || ALU_V1 !== 32'h10 || ALU_V2 !== 32'd3) begin failures++; $display("FAIL wake_issue: issue %0h v1 %0h v2 %0h want 1/10/3", ALU_issue, ALU_V1, ALU_V2); end
    endtask

    task automatic test_put_forward();
        put(4'd0, 1'b1, 32'd1, 1'b0, 32'd6, 4'd7);
        LSB_cdb_flag = 1'b1; LSB_cdb_idx = 4'd6; LSB_cdb_val = 32'hAB;
        tick(); idle();
        checks++; if (RS_ready_out !== 1'b1) begin failures++; $display("FAIL fwd_ready: got %0h want 1", RS_ready_out); end
        tick();
        checks++; if (ALU_issue !== 1'b1 || ALU_V2 !== 32'hAB || ALU_ROB_idx !== 4'd7) begin failures++; $display("FAIL fwd_issue: issue %0h v2 %0h rob %0h want 1/ab/7", ALU_issue, ALU_V2, ALU_ROB_idx); end
        tick();
    endtask

    task automatic test_rdy_hold();
        put(4'd0, 1'b1, 32'd11, 1'b1, 32'd12, 4'd8);
        tick(); idle();
        rdy = 1'b0;
        put(4'd1, 1'b1, 32'd0, 1'b1, 32'd0, 4'd9);
        tick(); idle();
        checks++; if (ALU_issue !== 1'b0 || RS_ready_out !== 1'b1 || RS_put_idx_out !== 4'd1) begin failures++; $display("FAIL rdy_hold: issue %0h ready %0h put %0h want 0/1/1", ALU_issue, RS_ready_out, RS_put_idx_out); end
        rdy = 1'b1;
        tick();
        checks++; if (ALU_issue !== 1'b1 || ALU_V1 !== 32'd11 || RS_ready_out !== 1'b0) begin failures++; $display("FAIL rdy_resume: issue %0h v1 %0h ready %0h want 1/b/0", ALU_issue, ALU_V1, RS_ready_out); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            put(4'(i), 1'b0, 32'(i), 1'b1, 32'h50 + 32'(i), 4'(i));
            tick();
        end
        idle();
        checks++; if (RS_full !== 1'b1 || RS_put_idx_out !== 4'd0 || RS_ready_out !== 1'b0) begin failures++; $display("FAIL full_state: full %0h put %0h ready %0h want 1/0/0", RS_full, RS_put_idx_out, RS_ready_out); end
        put(4'd0, 1'b1, 32'd1, 1'b1, 32'd2, 4'd15);
        tick(); idle();
        checks++; if (RS_ready_out !== 1'b0 || RS_full !== 1'b1) begin failures++; $display("FAIL full_ignore: ready %0h full %0h want 0/1", RS_ready_out, RS_full); end
        ALU_cdb_flag = 1'b1; ALU_cdb_idx = 4'd4; ALU_cdb_val = 32'h44;
        tick(); idle();
        checks++; if (RS_ready_out !== 1'b1 || RS_ready_idx_out !== 4'd4) begin failures++; $display("FAIL full_wake: ready %0h idx %0h want 1/4", RS_ready_out, RS_ready_idx_out); end
        tick();
        checks++; if (ALU_issue !== 1'b1 || ALU_V1 !== 32'h44 || ALU_V2 !== 32'h54 || ALU_ROB_idx !== 4'd4) begin failures++; $display("FAIL full_issue: issue %0h v1 %0h v2 %0h rob %0h want 1/44/54/4", ALU_issue, ALU_V1, ALU_V2, ALU_ROB_idx); end
        checks++; if (RS_full !== 1'b0 || RS_put_idx_out !== 4'd4) begin failures++; $display("FAIL full_free: full %0h put %0h want 0/4", RS_full, RS_put_idx_out); end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        tick(); idle();
        checks++; if (RS_full !== 1'b0 || RS_put_idx_out !== 4'd0) begin failures++; $display("FAIL clear_flush: full %0h put %0h want 0/0", RS_full, RS_put_idx_out); end
        put(4'd0, 1'b0, 32'd9, 1'b1, 32'd0, 4'd0); tick();
        put(4'd1, 1'b0, 32'd7, 1'b1, 32'd0, 4'd1); tick();
        put(4'd2, 1'b0, 32'd7, 1'b1, 32'd0, 4'd2); tick();
        idle();
        ALU_cdb_flag = 1'b1; ALU_cdb_idx = 4'd7; ALU_cdb_val = 32'h70;
        tick(); idle();
        checks++; if (RS_ready_out !== 1'b1 || RS_ready_idx_out !== 4'd1) begin failures++; $display("FAIL clear_pre: ready %0h idx %0h want 1/1", RS_ready_out, RS_ready_idx_out); end
        clear = 1'b1;
        tick(); idle();
        checks++; if (ALU_issue !== 1'b0 || RS_ready_out !== 1'b0) begin failures++; $display("FAIL clear_noissue: issue %0h ready %0h want 0/0", ALU_issue, RS_ready_out); end
        checks++; if (RS_full !== 1'b0 || RS_put_idx_out !== 4'd0) begin failures++; $display("FAIL clear_empty: full %0h put %0h want 0/0", RS_full, RS_put_idx_out); end
    endtask

    task automatic test_async_reset();
        put(4'd0, 1'b1, 32'd21, 1'b1, 32'd22, 4'd1); tick();
        put(4'd1, 1'b1, 32'd31, 1'b1, 32'd32, 4'd2); tick();
        idle();
        checks++; if (ALU_issue !== 1'b1 || RS_ready_out !== 1'b1 || RS_ready_idx_out !== 4'd1) begin failures++; $display("FAIL arst_pre: issue %0h ready %0h idx %0h want 1/1/1", ALU_issue, RS_ready_out, RS_ready_idx_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ALU_issue !== 1'b0 || RS_ready_out !== 1'b0) begin failures++; $display("FAIL arst_now: issue %0h ready %0h want 0/0", ALU_issue, RS_ready_out); end
        checks++; if (ALU_V1 !== 32'd0 || RS_full !== 1'b0 || RS_put_idx_out !== 4'd0) begin failures++; $display("FAIL arst_state: v1 %0h full %0h put %0h want 0/0/0", ALU_V1, RS_full, RS_put_idx_out); end
        tick();
        checks++; if (ALU_issue !== 1'b0) begin failures++; $display("FAIL arst_hold: issue %0h want 0", ALU_issue); end
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; RS_put_idx = '0;
        Dis_op = '0; Dis_imm = '0; Dis_rd = '0; Dis_ROB_idx = '0; Dis_PC = '0; Dis_BTB_PC = '0;
        Dis_BTB_predict = 1'b0; Dis_R1 = 1'b0; Dis_R2 = 1'b0; Dis_V1 = '0; Dis_V2 = '0;
        ALU_cdb_idx = '0; ALU_cdb_val = '0; LSB_cdb_idx = '0; LSB_cdb_val = '0;
        idle();
        #1;
        test_reset();
        #11 rst_n = 1'b1;
        tick();
        test_issue_ready();
        test_wakeup();
        test_put_forward();
        test_rdy_hold();
        test_full();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameters: RS_SIZE, 16, entry count; RS_IDX_W, 4, log2(RS_SIZE); ROB_IDX_W, 4, ROB tag width.
REQ-002 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low; rdy in 1 global enable.
REQ-003 SHALL have ports: clear in 1 misprediction flush; RS_flag in 1 put request; RS_put_idx in RS_IDX_W target entry.
REQ-004 SHALL have ports: Dis_op in 6; Dis_imm in 32; Dis_rd in 5; Dis_ROB_idx in ROB_IDX_W; Dis_PC in 32; Dis_BTB_PC in 32; Dis_BTB_predict in 1.
REQ-005 SHALL have ports: Dis_R1/Dis_R2 in 1 operand ready; Dis_V1/Dis_V2 in 32, value if ready, else ROB tag in low ROB_IDX_W bits.
REQ-006 SHALL have ports: ALU_cdb_flag in 1, ALU_cdb_idx in ROB_IDX_W, ALU_cdb_val in 32; LSB_cdb_flag, LSB_cdb_idx, LSB_cdb_val, same widths.
REQ-007 SHALL have ports: RS_put_idx_out out RS_IDX_W lowest free entry; RS_full out 1; RS_ready_out out 1 issuable entry exists; RS_ready_idx_out out RS_IDX_W lowest issuable entry.
REQ-008 SHALL have ports: ALU_issue out 1; ALU_op out 6; ALU_V1/ALU_V2/ALU_imm/ALU_PC/ALU_BTB_PC out 32; ALU_rd out 5; ALU_ROB_idx out ROB_IDX_W; ALU_BTB_predict out 1.

Function
REQ-009 SHALL hold per entry: busy, op, imm, rd, ROB tag, PC, BTB_PC, predict, R1, V1, R2, V2.
REQ-010 SHALL drive RS_put_idx_out combinationally as lowest-index non-busy entry, 0 when full; RS_full = all entries busy.
REQ-011 SHALL drive RS_ready_out/RS_ready_idx_out combinationally from registered state: lowest-index entry with busy&R1&R2; idx 0 when none.
REQ-012 SHALL, on rising edge with rdy=1, clear=0, RS_flag=1, write all Dis_* fields to entry RS_put_idx and set busy.
REQ-013 SHALL, at put, capture an operand as ready if Dis_Rx=0 and a CDB flag is high with matching tag, storing that CDB value (same-cycle forward).
REQ-014 SHALL, each edge with rdy=1, for every busy entry with Rx=0 and tag matching an active CDB, set Rx=1, Vx=CDB value; ALU CDB wins if both match.
REQ-015 SHALL, each edge with rdy=1, clear=0, RS_ready_out=1: register selected entry onto ALU_* outputs, set ALU_issue=1, clear that entry busy.
REQ-016 SHALL drive ALU_issue=0 on any edge with no issue; ALU_* data outputs hold last values.
REQ-017 SHALL give latency: put at edge N with both operands ready -> ALU_issue high after edge N+1; wakeup at edge N -> issue after edge N+1 at earliest.
REQ-018 SHALL issue at most one entry per cycle; remaining ready entries wait, lowest index first.
REQ-019 SHALL allow put and issue in the same edge; they never address the same entry since put targets a free entry.
REQ-020 SHALL ignore RS_flag when RS_full=1; no entry overwritten.
REQ-021 SHALL, when rdy=0, hold all state and drive ALU_issue=0.
REQ-022 SHALL, on clear=1 at an edge (with rdy=1), clear all busy bits and ALU_issue; clear overrides put, wakeup and issue.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously clear all busy/R1/R2 bits, ALU_issue=0, all ALU_* data outputs 0.
REQ-024 SHALL after reset present RS_full=0, RS_put_idx_out=0, RS_ready_out=0, RS_ready_idx_out=0.
REQ-025 SHALL abandon all entries if rst_n falls mid-operation; no issue occurs while rst_n=0.

Verification
REQ-026 Put ADD (op 1) R1=R2=1, V1=5, V2=7, ROB 3 at edge 0 -> after edge 1 ALU_issue=1, ALU_V1=5, ALU_V2=7, ALU_ROB_idx=3; RS_full=0 after.
REQ-027 Put R1=0 tag 2, R2=1; ALU_cdb tag 2 val 0x10 two cycles later -> no issue before wakeup; issue one cycle after with ALU_V1=0x10.
REQ-028 Put R2=0 tag 6 while LSB_cdb tag 6 val 0xAB same edge -> entry stored ready, issues next edge with ALU_V2=0xAB.
REQ-029 Fill 16 not-ready entries -> RS_full=1; 17th RS_flag ignored; one wakeup on entry 4 -> issue entry 4, RS_put_idx_out=4.
REQ-030 Entries 1 and 2 ready, clear=1 same edge -> no issue, RS_ready_out=0, RS_full=0, RS_put_idx_out=0.
REQ-031 Assert rst_n=0 mid-cycle with entries busy -> ALU_issue=0 and RS_ready_out=0 immediately, without clock edge.
